mem_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer sharing one single-ported memory bus between instruction fetch and the MEM-stage data port. It serializes requests, drives a registered Wishbone-style classic-cycle bus, waits on the slave's `ack`, and returns read data with a one-cycle `ready` pulse. It raises `stallreq_o` to the pipeline controller while any request is pending. A watchdog aborts bus cycles that are never acknowledged, and a starvation counter bounds the fetch wait under continuous data traffic.

---
 rtl/mem_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbiter/sequencer sharing one Wishbone-classic bus between instruction fetch
// and the data port, with a per-cycle watchdog and a fetch starvation bound.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        bus_cyc_q, bus_cyc_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        err_q, err_d;

  logic fetch_starved;
  logic is_data;

  assign fetch_starved = if_ce_i && (starve_cnt_q >= 4'(STARVE_LIMIT));
  assign is_data       = (state_q == DBUS);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    bus_cyc_d    = bus_cyc_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    if_data_d    = if_data_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_ce_i && !fetch_starved) begin
          state_d     = DBUS;
          bus_cyc_d   = 1'b1;
          bus_we_d    = d_we_i;
          bus_addr_d  = d_addr_i;
          bus_sel_d   = d_sel_i;
          bus_wdata_d = d_wdata_i;
          wd_cnt_d    = '0;
          if (if_ce_i && (starve_cnt_q != 4'hF)) starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (if_ce_i) begin
          state_d      = IBUS;
          bus_cyc_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr_i;
          bus_sel_d    = 4'b1111;
          bus_wdata_d  = '0;
          wd_cnt_d     = '0;
          starve_cnt_d = '0;
        end
      end
      IBUS, DBUS: begin
        // Ack is tested first so an ack on the last watchdog cycle still completes.
        if (bus_ack_i) begin
          state_d   = DONE;
          bus_cyc_d = 1'b0;
          if (!bus_we_q) begin
            if (is_data) d_rdata_d = bus_rdata_i;
            else         if_data_d = bus_rdata_i;
          end
          if (is_data) d_ready_d  = 1'b1;
          else         if_ready_d = 1'b1;
        end else if (wd_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d   = DONE;
          bus_cyc_d = 1'b0;
          err_d     = 1'b1;
          if (is_data) begin
            d_rdata_d = '0;
            d_ready_d = 1'b1;
          end else begin
            if_data_d  = '0;
            if_ready_d = 1'b1;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
      bus_cyc_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_sel_q    <= '0;
      bus_wdata_q  <= '0;
      if_data_q    <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      bus_cyc_q    <= bus_cyc_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      if_data_q    <= if_data_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      err_q        <= err_d;
    end
  end

  assign bus_cyc_o   = bus_cyc_q;
  assign bus_stb_o   = bus_cyc_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;
  assign err_o       = err_q;
  assign stallreq_o  = (d_ce_i & ~d_ready_q) | (if_ce_i & ~if_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: behavioural slave with programmable wait
// states, a bus monitor, and hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i, d_ce_i, d_we_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] if_data_o, d_rdata_o;
  logic        if_ready_o, d_ready_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i, err_o, stallreq_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit          slave_en   = 1'b0;
  int          slave_wait = 0;
  logic [31:0] slave_data = '0;

  int          cyc_hi_cnt = 0;
  int          gnt_cnt    = 0;
  logic [15:0] gnt_seq    = '0;
  int          stable_viol = 0;
  int          ir_cnt = 0, dr_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .err_o(err_o), .stallreq_o(stallreq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_d, input int budget);
    int n = 0;
    while (!(is_d ? d_ready_o : if_ready_o) && n < budget) begin
      tick();
      n++;
    end
    check(is_d ? "d_ready_seen" : "if_ready_seen", 32'(is_d ? d_ready_o : if_ready_o), 32'd1);
  endtask

  // Slave: acks after slave_wait wait states, driven just after the rising edge.
  initial begin
    int s_cnt = 0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_cyc_o && slave_en) begin
        bus_ack_i = (s_cnt == slave_wait);
        if (s_cnt == slave_wait) bus_rdata_i = slave_data;
        s_cnt++;
      end else begin
        bus_ack_i = 1'b0;
        s_cnt     = 0;
      end
    end
  end

  // Monitor: grant order (1 = data, recognised by a non-1111 byte select), cycle lengths, stability.
  initial begin
    logic        cyc_prev = 1'b0;
    logic [68:0] prev_bus = '0;
    forever begin
      @(negedge clk);
      if (bus_cyc_o) begin
        cyc_hi_cnt++;
        if (!cyc_prev) begin
          gnt_cnt++;
          gnt_seq = {gnt_seq[14:0], (bus_sel_o != 4'hF)};
        end else if ({bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} != prev_bus) begin
          stable_viol++;
        end
      end
      prev_bus = {bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o};
      cyc_prev = bus_cyc_o;
      if (if_ready_o) ir_cnt++;
      if (d_ready_o)  dr_cnt++;
      if (err_o)      err_cnt++;
    end
  end

  initial begin
    int base, ir_base, dr_base, err_base;
    rst = 1'b0;
    if_ce_i = 0; d_ce_i = 0; d_we_i = 0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_sel_i = '0;
    tick(); tick();
    check("rst_ctrl", {25'd0, bus_cyc_o, bus_stb_o, bus_we_o, if_ready_o, d_ready_o, err_o, stallreq_o}, 32'd0);
    check("rst_addr", bus_addr_o, 32'd0);
    check("rst_data", if_data_o | d_rdata_o | bus_wdata_o, 32'd0);
    rst = 1'b1;

    // Fetch read, zero-wait slave
    slave_en = 1; slave_wait = 0; slave_data = 32'h2401_0005;
    if_ce_i = 1; if_addr_i = 32'h100;
    #1 check("fetch_stall_req", 32'(stallreq_o), 32'd1);
    tick();
    check("fetch_cyc", {30'd0, bus_cyc_o, bus_stb_o}, 32'd3);
    check("fetch_addr", bus_addr_o, 32'h100);
    check("fetch_sel_we", {27'd0, bus_sel_o, bus_we_o}, {27'd0, 4'hF, 1'b0});
    tick();
    check("fetch_ready", {30'd0, if_ready_o, bus_cyc_o}, 32'd2);
    check("fetch_data", if_data_o, 32'h2401_0005);
    check("fetch_stall_at_ready", 32'(stallreq_o), 32'd0);
    if_ce_i = 0;
    tick();
    check("fetch_ready_pulse", {30'd0, if_ready_o, stallreq_o}, 32'd0);

    // Simultaneous store and fetch: store first, fetch granted the cycle after ready
    slave_data = 32'hDEAD_BEEF;
    d_ce_i = 1; d_we_i = 1; d_addr_i = 32'h204; d_sel_i = 4'b0100; d_wdata_i = 32'h00AB_0000;
    if_ce_i = 1; if_addr_i = 32'h108;
    tick();
    check("st_cyc_we", {30'd0, bus_cyc_o, bus_we_o}, 32'd3);
    check("st_addr", bus_addr_o, 32'h204);
    check("st_sel", 32'(bus_sel_o), 32'h4);
    check("st_wdata", bus_wdata_o, 32'h00AB_0000);
    tick();
    check("st_ready", {30'd0, d_ready_o, if_ready_o}, 32'd2);
    check("st_rdata_kept", d_rdata_o, 32'd0);
    check("st_stall_fetch_waiting", 32'(stallreq_o), 32'd1);
    d_ce_i = 0; d_we_i = 0;
    tick();
    check("idle_gap", 32'(bus_cyc_o), 32'd0);
    tick();
    check("fetch2_cyc", {31'd0, bus_cyc_o}, 32'd1);
    check("fetch2_addr", bus_addr_o, 32'h108);
    tick();
    check("fetch2_ready", 32'(if_ready_o), 32'd1);
    check("fetch2_data", if_data_o, 32'hDEAD_BEEF);
    if_ce_i = 0;
    tick();

    // Starvation bound: both ports requesting continuously
    slave_data = 32'h1111_2222;
    base = gnt_cnt; gnt_seq = '0;
    d_ce_i = 1; d_we_i = 0; d_addr_i = 32'h200; d_sel_i = 4'b1110;
    if_ce_i = 1; if_addr_i = 32'h100;
    for (int n = 0; n < 80 && (gnt_cnt - base) < 10; n++) tick();
    d_ce_i = 0; if_ce_i = 0;
    repeat (6) tick();
    check("starve_grants", 32'(gnt_cnt - base), 32'd10);
    check("starve_seq", 32'(gnt_seq[9:0]), 32'(10'b1111011110));

    // Timeout on a load with no ack
    slave_en = 0; cyc_hi_cnt = 0; err_base = err_cnt;
    d_ce_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_sel_i = 4'hF;
    wait_ready(1'b1, 40);
    check("to_err", {30'd0, err_o, bus_cyc_o}, 32'd2);
    check("to_cyc_len", 32'(cyc_hi_cnt), 32'd16);
    check("to_rdata", d_rdata_o, 32'd0);
    d_ce_i = 0;
    tick();
    check("to_pulse", {30'd0, err_o, d_ready_o}, 32'd0);
    check("to_err_count", 32'(err_cnt - err_base), 32'd1);

    // Ack in the 16th cycle wins over the watchdog
    slave_en = 1; slave_wait = 15; slave_data = 32'h5A5A_1234; cyc_hi_cnt = 0;
    d_ce_i = 1; d_addr_i = 32'h304;
    wait_ready(1'b1, 40);
    check("late_ack_err", 32'(err_o), 32'd0);
    check("late_ack_len", 32'(cyc_hi_cnt), 32'd16);
    check("late_ack_data", d_rdata_o, 32'h5A5A_1234);
    d_ce_i = 0;
    tick();
    check("late_ack_err_count", 32'(err_cnt - err_base), 32'd1);

    // Slow slave store: bus fields held through 5 wait states
    slave_wait = 5; cyc_hi_cnt = 0; stable_viol = 0;
    d_ce_i = 1; d_we_i = 1; d_addr_i = 32'h208; d_sel_i = 4'b0011; d_wdata_i = 32'hCAFE_F00D;
    wait_ready(1'b1, 40);
    check("slow_len", 32'(cyc_hi_cnt), 32'd6);
    check("slow_stable", 32'(stable_viol), 32'd0);
    check("slow_wdata", bus_wdata_o, 32'hCAFE_F00D);
    check("slow_addr_sel", bus_addr_o | {28'd0, bus_sel_o}, 32'h20B);
    check("slow_rdata_kept", d_rdata_o, 32'h5A5A_1234);
    d_ce_i = 0; d_we_i = 0;
    tick();

    // Fetch ce held through the ready cycle: no duplicate bus cycle
    slave_wait = 0; slave_data = 32'h1357_9BDF; base = gnt_cnt;
    if_ce_i = 1; if_addr_i = 32'h10C;
    wait_ready(1'b0, 10);
    @(posedge clk);
    #1 if_ce_i = 0;
    repeat (5) tick();
    check("held_ce_grants", 32'(gnt_cnt - base), 32'd1);
    check("held_ce_data", if_data_o, 32'h1357_9BDF);

    // Reset during a data wait
    slave_en = 0; ir_base = ir_cnt; dr_base = dr_cnt; err_base = err_cnt;
    d_ce_i = 1; d_addr_i = 32'h30C;
    repeat (3) tick();
    check("pre_rst_cyc", 32'(bus_cyc_o), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_async_cyc", {30'd0, bus_cyc_o, bus_stb_o}, 32'd0);
    check("rst_async_addr", bus_addr_o, 32'd0);
    check("rst_async_data", if_data_o | d_rdata_o, 32'd0);
    d_ce_i = 0;
    tick(); tick();
    check("rst_no_pulses", 32'((ir_cnt - ir_base) + (dr_cnt - dr_base) + (err_cnt - err_base)), 32'd0);
    rst = 1'b1;
    slave_en = 1; slave_data = 32'h0BAD_C0DE;
    if_ce_i = 1; if_addr_i = 32'h140;
    tick();
    check("post_rst_grant", bus_addr_o, 32'h140);
    tick();
    check("post_rst_ready", 32'(if_ready_o), 32'd1);
    check("post_rst_data", if_data_o, 32'h0BAD_C0DE);
    if_ce_i = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
